ifu_prefetch: RTL and testbench

//  Instruction-fetch front end: owns the fetch PC, issues in-order requests to

---
 rtl/ifu_prefetch.sv | 153 +++++++++++++++
 tb/tb_ifu_prefetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited in-order
// imem requests, pairs responses with their PCs and queues them for decode.
module ifu_prefetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
   localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);
   localparam logic [AW-1:0] P_ONE   = AW'(1);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
   } entry_t;

   state_t        state, state_nxt;
   logic [CW-1:0] drop_cnt, drop_nxt;
   logic [CW-1:0] count, outstanding;
   logic [31:0]   fetch_pc;

   entry_t        fifo_mem [DEPTH];
   logic [AW-1:0] fifo_head, fifo_tail;
   logic [31:0]   pcq_mem [DEPTH];
   logic [AW-1:0] pcq_head, pcq_tail;

   logic          req_fire, push, pop;
   logic [CW:0]   credit_used;
   logic          unused_bits;

   // The low PC bits of a redirect are architecturally ignored.
   assign unused_bits = ^redirect_pc[1:0];

   // FIFO entries plus in-flight requests share one credit pool, so a response
   // always has a FIFO slot waiting for it.
   assign credit_used    = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDITS);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign push = imem_resp_valid && !redirect_valid && (state == RUN);

   assign inst_valid = !rst && !redirect_valid && (count != '0);
   assign pop        = inst_valid && inst_ready;
   assign inst       = fifo_mem[fifo_head].data;
   assign inst_pc    = fifo_mem[fifo_head].pc;

   // Drop bookkeeping: a redirect re-arms the drop count from whatever is still
   // in flight, excluding a response that lands in the redirect cycle itself.
   always_comb begin
      drop_nxt  = drop_cnt;
      state_nxt = state;
      if (redirect_valid) begin
         drop_nxt = imem_resp_valid ? (outstanding - C_ONE) : outstanding;
      end else if ((state == FLUSH) && imem_resp_valid) begin
         drop_nxt = drop_cnt - C_ONE;
      end
      state_nxt = (drop_nxt != '0) ? FLUSH : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         drop_cnt <= drop_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Every response retires one in-flight request, kept or dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({req_fire, imem_resp_valid})
            2'b10:   outstanding <= outstanding + C_ONE;
            2'b01:   outstanding <= outstanding - C_ONE;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcq_head <= '0;
         pcq_tail <= '0;
      end else begin
         if (req_fire)        pcq_tail <= pcq_tail + P_ONE;
         if (imem_resp_valid) pcq_head <= pcq_head + P_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) pcq_mem[pcq_tail] <= fetch_pc;
   end

   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         fifo_head <= '0;
         fifo_tail <= '0;
         count     <= '0;
      end else begin
         if (push) fifo_tail <= fifo_tail + P_ONE;
         if (pop)  fifo_head <= fifo_head + P_ONE;
         case ({push, pop})
            2'b10:   count <= count + C_ONE;
            2'b01:   count <= count - C_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[fifo_tail] <= '{data: imem_resp_data, pc: pcq_mem[pcq_head]};
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && (count == C_FULL)));
   a_resp_tracked : assert property (@(posedge clk) disable iff (rst)
      !(imem_resp_valid && (outstanding == '0)));
   a_credit_cap : assert property (@(posedge clk) disable iff (rst)
      credit_used <= CREDITS);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: in-order random-latency memory, queue-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_ifu_prefetch;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } fl_t;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // memory environment
   logic [31:0] mem_q[$];
   int          mem_due[$];
   int          lat_min = 1, lat_max = 1, stall_pct = 0;
   bit          mem_hold = 1'b0;

   // reference model
   ent_t        m_fifo[$];
   fl_t         m_fl[$];
   logic [31:0] m_pc = RESET_PC;

   // observed handshakes, for the directed literal checks
   logic [31:0] acc_log[$];
   logic [31:0] dlv_log[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (!mem_hold && mem_q.size() > 0 && mem_due[0] <= cyc &&
          $urandom_range(99) >= stall_pct) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mem_q[0]);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
   endtask

   task automatic clear_logs();
      acc_log.delete();
      dlv_log.delete();
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         rst = 1'b1;
         redirect_valid = 1'b0;
         #1;
         chk("rst_req_valid", imem_req_valid, 1'b0);
         chk("rst_inst_valid", inst_valid, 1'b0);
      end
      mem_hold = 1'b0;
   endtask

   // Compare process: outputs against the model mid-cycle, then advance model
   // and memory by what happens at the coming rising edge.
   always @(negedge clk) begin
      logic exp_rv, exp_iv;
      fl_t  f;
      exp_rv = !rst && !redirect_valid && (m_fifo.size() + m_fl.size() < DEPTH);
      exp_iv = !rst && !redirect_valid && (m_fifo.size() != 0);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", inst_valid, exp_iv);
      if (exp_iv) begin
         chk("inst_pc", inst_pc, m_fifo[0].pc);
         chk("inst", inst, m_fifo[0].data);
      end

      if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
      if (inst_valid && inst_ready) dlv_log.push_back(inst_pc);

      if (rst) begin
         mem_q.delete();
         mem_due.delete();
      end else begin
         if (imem_resp_valid && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            void'(mem_due.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            mem_due.push_back(cyc + $urandom_range(lat_max, lat_min));
         end
      end

      if (rst) begin
         m_pc = RESET_PC;
         m_fifo.delete();
         m_fl.delete();
      end else if (redirect_valid) begin
         m_pc = {redirect_pc[31:2], 2'b00};
         m_fifo.delete();
         if (imem_resp_valid && m_fl.size() > 0) void'(m_fl.pop_front());
         foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      end else begin
         if (exp_iv && inst_ready) void'(m_fifo.pop_front());
         if (imem_resp_valid && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!f.stale) m_fifo.push_back('{pc: f.pc, data: mem_word(f.pc)});
         end
         if (exp_rv && imem_req_ready) begin
            m_fl.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
   end

   initial begin
      int k;
      // 1: streaming from reset with 1-cycle memory
      lat_min = 1; lat_max = 1; stall_pct = 0;
      imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset(2);
      step(); rst = 1'b0; clear_logs();
      repeat (15) step();
      chk("t1_acc_cnt_ge4", 32'(acc_log.size() >= 4), 32'd1);
      chk("t1_dlv_cnt_ge4", 32'(dlv_log.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("t1_req_addr", acc_log[i], RESET_PC + 32'(4 * i));
         chk("t1_inst_pc", dlv_log[i], RESET_PC + 32'(4 * i));
      end

      // 2: decode stalled for 10 cycles
      inst_ready = 1'b0;
      do_reset(1);
      step(); rst = 1'b0; clear_logs();
      repeat (9) step();
      #1;
      chk("t2_req_valid_low", imem_req_valid, 1'b0);
      chk("t2_accepts", 32'(acc_log.size()), 32'd2);
      chk("t2_no_delivery", 32'(dlv_log.size()), 32'd0);
      step(); inst_ready = 1'b1;
      repeat (8) step();
      chk("t2_dlv0", dlv_log[0], 32'h8000_0000);
      chk("t2_dlv1", dlv_log[1], 32'h8000_0004);
      chk("t2_dlv2", dlv_log[2], 32'h8000_0008);

      // 3: redirect with two requests in flight
      lat_min = 4; lat_max = 4;
      do_reset(1);
      step(); rst = 1'b0;
      step();
      step(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0103; clear_logs();
      step(); redirect_valid = 1'b0;
      repeat (20) step();
      chk("t3_first_req", acc_log[0], 32'h8000_0100);
      chk("t3_first_dlv", dlv_log[0], 32'h8000_0100);
      chk("t3_second_dlv", dlv_log[1], 32'h8000_0104);

      // 4: redirect coinciding with the only in-flight response
      lat_min = 2; lat_max = 2;
      do_reset(1);
      step(); rst = 1'b0; imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0;
      k = 0;
      while (!imem_resp_valid && k < 10) begin step(); k++; end
      chk("t4_resp_seen", imem_resp_valid, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; clear_logs();
      step(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
      repeat (10) step();
      chk("t4_first_req", acc_log[0], 32'h8000_0200);
      chk("t4_first_dlv", dlv_log[0], 32'h8000_0200);

      // 5: redirect to the top of the address space
      lat_min = 1; lat_max = 1;
      step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; clear_logs();
      step(); redirect_valid = 1'b0;
      repeat (12) step();
      chk("t5_req0", acc_log[0], 32'hFFFF_FFFC);
      chk("t5_req1", acc_log[1], 32'h0000_0000);
      chk("t5_dlv0", dlv_log[0], 32'hFFFF_FFFC);
      chk("t5_dlv1", dlv_log[1], 32'h0000_0000);

      // 6: reset with a buffered word and one response pending
      lat_min = 3; lat_max = 3; inst_ready = 1'b0;
      do_reset(1);
      step(); rst = 1'b0;
      k = 0;
      while (!imem_resp_valid && k < 10) begin step(); k++; end
      chk("t6_resp_seen", imem_resp_valid, 1'b1);
      mem_hold = 1'b1;
      do_reset(1);
      step(); rst = 1'b0; inst_ready = 1'b1; clear_logs();
      repeat (12) step();
      chk("t6_first_req", acc_log[0], 32'h8000_0000);
      chk("t6_first_dlv", dlv_log[0], 32'h8000_0000);

      // random traffic
      lat_min = 1; lat_max = 4; stall_pct = 20;
      for (int i = 0; i < 4000; i++) begin
         step();
         rst            = ($urandom_range(199) == 0);
         redirect_valid = ($urandom_range(19) == 0);
         redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                   : 32'($urandom);
         imem_req_ready = ($urandom_range(9) < 7);
         inst_ready     = ($urandom_range(9) < 7);
      end
      step(); rst = 1'b0; redirect_valid = 1'b0;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
